// File: rtl/score_display_driver.sv
// Converts two binary scores to BCD with a shared sequential double-dabble FSM and
// scans them onto a 4-digit common-anode display. Optional score flash: SCORE_FLASH_EN.
module score_display_driver #(
    parameter int unsigned SCORE_W      = 7,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned FLASH_CYCLES = 100000000,
    parameter int unsigned FLASH_SHIFT  = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    input  logic [1:0]         increaseScore,
    output logic [7:0]         bcd1,
    output logic [7:0]         bcd2,
    output logic               busy,
    output logic [6:0]         seg_n,
    output logic [3:0]         dig_n
);
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [14:0] r_sh1, r_sh2;
    logic [6:0]  r_cap1, r_cap2, r_last1, r_last2;
    logic [2:0]  r_iter;
    logic [7:0]  r_bcd1, r_bcd2;
    logic        r_busy;
    logic [REF_W-1:0] r_refresh;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg_n;
    logic [3:0]  r_dig_n;

    logic [6:0]  w_clamp1, w_clamp2;
    logic        w_diff, w_capture;
    logic [3:0]  w_digit, w_dig_n;
    logic        w_blank, w_flash1, w_flash2;

    assign w_clamp1  = (score1 > SCORE_W'(99)) ? 7'd99 : score1[6:0];
    assign w_clamp2  = (score2 > SCORE_W'(99)) ? 7'd99 : score2[6:0];
    assign w_diff    = (w_clamp1 != r_last1) || (w_clamp2 != r_last2);
    assign w_capture = (w_state_nxt == ST_LOAD);

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
    function automatic logic [14:0] dabble_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // DONE re-compares so a change that arrived while busy starts straight away.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_diff) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_iter == 3'd7) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = w_diff ? ST_LOAD : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Converter datapath; iteration 1 happens on the LOAD->SHIFT edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_cap1  <= '0;
            r_cap2  <= '0;
            r_last1 <= '0;
            r_last2 <= '0;
            r_iter  <= '0;
            r_bcd1  <= '0;
            r_bcd2  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_capture) begin
                        r_sh1  <= {8'd0, w_clamp1};
                        r_sh2  <= {8'd0, w_clamp2};
                        r_cap1 <= w_clamp1;
                        r_cap2 <= w_clamp2;
                        r_iter <= 3'd0;
                    end
                end
                ST_LOAD: begin
                    r_sh1  <= dabble_step(r_sh1);
                    r_sh2  <= dabble_step(r_sh2);
                    r_iter <= 3'd1;
                end
                ST_SHIFT: begin
                    if (r_iter != 3'd7) begin
                        r_sh1  <= dabble_step(r_sh1);
                        r_sh2  <= dabble_step(r_sh2);
                        r_iter <= r_iter + 3'd1;
                    end else begin
                        r_bcd1  <= r_sh1[14:7];
                        r_bcd2  <= r_sh2[14:7];
                        r_last1 <= r_cap1;
                        r_last2 <= r_cap2;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_FLASH_EN
    localparam int unsigned FL_W = $clog2(FLASH_CYCLES + 1);
    logic [FL_W-1:0] r_flash1, r_flash2;

    // Per-player flash timers; a pulse (re)loads, otherwise count down to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash1 <= '0;
            r_flash2 <= '0;
        end else begin
            if (increaseScore[0])     r_flash1 <= FL_W'(FLASH_CYCLES);
            else if (r_flash1 != '0)  r_flash1 <= r_flash1 - FL_W'(1);
            if (increaseScore[1])     r_flash2 <= FL_W'(FLASH_CYCLES);
            else if (r_flash2 != '0)  r_flash2 <= r_flash2 - FL_W'(1);
        end
    end

    assign w_flash1 = (r_flash1 != '0) && r_flash1[FLASH_SHIFT];
    assign w_flash2 = (r_flash2 != '0) && r_flash2[FLASH_SHIFT];
`else
    logic w_unused;
    assign w_unused = ^{increaseScore, FLASH_CYCLES[0], FLASH_SHIFT[0]};
    assign w_flash1 = 1'b0;
    assign w_flash2 = 1'b0;
`endif

    // Digit select with leading-zero blanking on tens digits.
    always_comb begin
        w_digit = bcd1[7:4];
        w_blank = 1'b0;
        w_dig_n = 4'b0111;
        case (r_idx)
            2'd0: begin w_digit = r_bcd1[7:4]; w_blank = (r_bcd1[7:4] == 4'd0) || w_flash1; w_dig_n = 4'b0111; end
            2'd1: begin w_digit = r_bcd1[3:0]; w_blank = w_flash1;                          w_dig_n = 4'b1011; end
            2'd2: begin w_digit = r_bcd2[7:4]; w_blank = (r_bcd2[7:4] == 4'd0) || w_flash2; w_dig_n = 4'b1101; end
            default: begin w_digit = r_bcd2[3:0]; w_blank = w_flash2;                       w_dig_n = 4'b1110; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
            r_seg_n   <= 7'h7F;
            r_dig_n   <= 4'hF;
        end else begin
            if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + REF_W'(1);
            end
            r_seg_n <= w_blank ? 7'h7F : seg7(w_digit);
            r_dig_n <= w_dig_n;
        end
    end

    assign bcd1  = r_bcd1;
    assign bcd2  = r_bcd2;
    assign busy  = r_busy;
    assign seg_n = r_seg_n;
    assign dig_n = r_dig_n;
endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver: conversion latency, scan, clamp, reset abort, flash.
module tb_score_display_driver;
    localparam int unsigned SCORE_W = 7;
    localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000,
                           S4 = 7'b0011001, S6 = 7'b0000010, S7 = 7'b1111000;
`ifdef SCORE_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [SCORE_W-1:0] score1, score2;
    logic [1:0]         increaseScore;
    logic [7:0]         bcd1, bcd2;
    logic               busy;
    logic [6:0]         seg_n;
    logic [3:0]         dig_n;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    score_display_driver #(
        .SCORE_W(SCORE_W), .REFRESH_DIV(4), .FLASH_CYCLES(64), .FLASH_SHIFT(3)
    ) dut (
        .clk(clk), .reset(reset), .score1(score1), .score2(score2),
        .increaseScore(increaseScore), .bcd1(bcd1), .bcd2(bcd2), .busy(busy),
        .seg_n(seg_n), .dig_n(dig_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for a conversion to start and finish; timeout counts as a failure.
    task automatic wait_conv(input string name);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
    endtask

    // Monitor: every change of the BCD outputs outside reset must match the next expected result.
    initial begin
        logic [15:0] prev, e;
        prev = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset && ({bcd1, bcd2} !== prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bcd: got %h with nothing expected", {bcd1, bcd2});
                end else begin
                    e = exp_q.pop_front();
                    chk("bcd_result", 32'({bcd1, bcd2}), 32'(e));
                end
            end
            prev = {bcd1, bcd2};
        end
    end

    initial begin
        logic [6:0] exp_seg[4];
        logic [3:0] exp_dig[4];
        logic [3:0] pd;
        bit found;
        int mcnt;
        bit blank2, pulsed2;

        exp_dig[0] = 4'b0111; exp_dig[1] = 4'b1011; exp_dig[2] = 4'b1101; exp_dig[3] = 4'b1110;
        reset = 1'b1; score1 = 7'd42; score2 = 7'd7; increaseScore = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_bcd1", 32'(bcd1), 32'h0);
        chk("rst_bcd2", 32'(bcd2), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dig", 32'(dig_n), 32'hF);

        // 42/7 after release: negedge n follows edge E+n-1.
        exp_q.push_back(16'h4207);
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("busy_rise", 32'(busy), 32'd1);
                chk("dig_first", 32'(dig_n), 32'b0111);
            end
            if (n == 8) chk("bcd1_before_e8", 32'(bcd1), 32'h0);
            if (n == 9) begin
                chk("bcd1_e8", 32'(bcd1), 32'h42);
                chk("bcd2_e8", 32'(bcd2), 32'h07);
                chk("busy_e8", 32'(busy), 32'd1);
            end
            if (n == 10) chk("busy_e9", 32'(busy), 32'd0);
        end

        // Scan: 4 clocks per digit, tens of P2 blanked.
        exp_seg[0] = S4; exp_seg[1] = S2; exp_seg[2] = 7'h7F; exp_seg[3] = S7;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            pd = dig_n;
            @(negedge clk);
            if (dig_n == 4'b0111 && pd != 4'b0111) found = 1'b1;
        end
        chk("scan_sync", 32'(found), 32'd1);
        for (int k = 0; k < 16; k++) begin
            chk("scan_dig", 32'(dig_n), 32'(exp_dig[k/4]));
            chk("scan_seg", 32'(seg_n), 32'(exp_seg[k/4]));
            @(negedge clk);
        end

        // Clamp above 99, then a clamped-equal input must not restart.
        exp_q.push_back(16'h9999);
        score1 = 7'd120; score2 = 7'd99;
        wait_conv("clamp");
        chk("clamp_bcd1", 32'(bcd1), 32'h99);
        score1 = 7'd110; score2 = 7'd99;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_reconvert", 32'(busy), 32'd0);
        end

        // Change while busy is deferred to a back-to-back second conversion.
        exp_q.push_back(16'h1020);
        exp_q.push_back(16'h5520);
        score1 = 7'd10; score2 = 7'd20;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (n == 3) score1 = 7'd55;
            if (n == 9) begin
                chk("first_bcd1", 32'(bcd1), 32'h10);
                chk("first_bcd2", 32'(bcd2), 32'h20);
            end
            if (n == 10) chk("busy_b2b", 32'(busy), 32'd1);
            if (n == 17) chk("bcd1_before_e17", 32'(bcd1), 32'h10);
            if (n == 18) chk("second_bcd1", 32'(bcd1), 32'h55);
            if (n == 19) chk("busy_after_2nd", 32'(busy), 32'd0);
        end

        // Reset mid-conversion aborts; conversion restarts after release.
        exp_q.push_back(16'h3364);
        score1 = 7'd33; score2 = 7'd64;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_bcd1", 32'(bcd1), 32'h0);
        chk("midrst_bcd2", 32'(bcd2), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_seg", 32'(seg_n), 32'h7F);
        chk("midrst_dig", 32'(dig_n), 32'hF);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_conv("restart");
        chk("restart_bcd", 32'({bcd1, bcd2}), 32'h3364);

        // P2 score pulses: flash model (blank while count nonzero with bit 3 set).
        exp_seg[0] = S3; exp_seg[1] = S3; exp_seg[2] = S6; exp_seg[3] = S4;
        mcnt = 0; pulsed2 = 1'b0;
        for (int c = 0; c < 140; c++) begin
            increaseScore = 2'b00;
            if (c == 0) increaseScore = 2'b10;
            else if (mcnt == 20 && !pulsed2) begin
                increaseScore = 2'b10;
                pulsed2 = 1'b1;
            end
            @(posedge clk);
            blank2 = FLASH_ON && (mcnt != 0) && (mcnt[3] == 1'b1);
            if (increaseScore[1]) mcnt = 64;
            else if (mcnt > 0) mcnt--;
            @(negedge clk);
            case (dig_n)
                4'b0111: chk("flash_p1_tens", 32'(seg_n), 32'(exp_seg[0]));
                4'b1011: chk("flash_p1_ones", 32'(seg_n), 32'(exp_seg[1]));
                4'b1101: chk("flash_p2_tens", 32'(seg_n), blank2 ? 32'h7F : 32'(exp_seg[2]));
                4'b1110: chk("flash_p2_ones", 32'(seg_n), blank2 ? 32'h7F : 32'(exp_seg[3]));
                default: chk("flash_onehot", 32'(dig_n), 32'hE);
            endcase
        end
        increaseScore = 2'b00;
        chk("flash_reloaded", 32'(pulsed2), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("zero_seg_sanity", 32'(S0), 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end
endmodule
